// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
  localparam int unsigned PERF_CNT_W      = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; slave = controller, master = datapath.
// HAZARD_PERF_EN adds the performance counter outputs.
interface hazard_ctrl_if #(
  parameter int unsigned RAW = 5
);
  logic [RAW-1:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i;
  logic [RAW-1:0] RdE_i, RdM_i, RdW_i;
  logic           RegWriteM_i, RegWriteW_i;
  logic [1:0]     ResultSrcE_i;
  logic           PCSrcE_i, MemAccessM_i, MemReady_i;
  logic           MemReq_o;
  logic           StallF_o, StallD_o, StallE_o, StallM_o;
  logic           FlushD_o, FlushE_o, FlushW_o;
  logic [1:0]     ForwardAE_o, ForwardBE_o;
  logic           MemErr_o;
`ifdef HAZARD_PERF_EN
  logic [31:0]    StallCnt_o, FlushCnt_o, LwStallCnt_o;
`endif

  modport slave (
    input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
    input  RegWriteM_i, RegWriteW_i, ResultSrcE_i, PCSrcE_i, MemAccessM_i, MemReady_i,
    output MemReq_o, StallF_o, StallD_o, StallE_o, StallM_o,
    output FlushD_o, FlushE_o, FlushW_o, ForwardAE_o, ForwardBE_o, MemErr_o
`ifdef HAZARD_PERF_EN
    , output StallCnt_o, FlushCnt_o, LwStallCnt_o
`endif
  );

  modport master (
    output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
    output RegWriteM_i, RegWriteW_i, ResultSrcE_i, PCSrcE_i, MemAccessM_i, MemReady_i,
    input  MemReq_o, StallF_o, StallD_o, StallE_o, StallM_o,
    input  FlushD_o, FlushE_o, FlushW_o, ForwardAE_o, ForwardBE_o, MemErr_o
`ifdef HAZARD_PERF_EN
    , input StallCnt_o, FlushCnt_o, LwStallCnt_o
`endif
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Execute-stage operand forward select for one source register; M result beats W result.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned RAW = 5
) (
  input  logic           reg_write_m,
  input  logic [RAW-1:0] rd_m,
  input  logic           reg_write_w,
  input  logic [RAW-1:0] rd_w,
  input  logic [RAW-1:0] rs_e,
  output fwd_sel_e       fwd_c
);

  // x0 is hardwired to zero, so a write to it never forwards
  always_comb begin
    fwd_c = FWD_REG;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd_c = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward generation plus data-memory wait FSM with timeout.
// Optional HAZARD_PERF_EN adds stall/flush/load-use event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT            = 16,
  parameter int unsigned TIMEOUT_WIDTH          = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  hazard_ctrl_if.slave  hz
);

  mem_state_e               state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     mem_err_q, mem_err_d;
  logic                     mem_req, mem_stall, lw_stall, timeout_hit;
  logic                     stall_f, stall_d, stall_e, stall_m;
  logic                     flush_d, flush_e, flush_w;
  fwd_sel_e                 fwd_a, fwd_b;

  fwd_sel #(.RAW(REGISTER_ADDRESS_WIDTH)) u_fwd_a (
    .reg_write_m (hz.RegWriteM_i),
    .rd_m        (hz.RdM_i),
    .reg_write_w (hz.RegWriteW_i),
    .rd_w        (hz.RdW_i),
    .rs_e        (hz.Rs1E_i),
    .fwd_c       (fwd_a)
  );

  fwd_sel #(.RAW(REGISTER_ADDRESS_WIDTH)) u_fwd_b (
    .reg_write_m (hz.RegWriteM_i),
    .rd_m        (hz.RdM_i),
    .reg_write_w (hz.RegWriteW_i),
    .rd_w        (hz.RdW_i),
    .rs_e        (hz.Rs2E_i),
    .fwd_c       (fwd_b)
  );

  assign lw_stall = (hz.ResultSrcE_i == RESULT_SRC_LOAD) && (hz.RdE_i != '0) &&
                    ((hz.RdE_i == hz.Rs1D_i) || (hz.RdE_i == hz.Rs2D_i));
  assign timeout_hit = (cnt_q == TIMEOUT_WIDTH'(MEM_TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Wait-state FSM; a ready response on the timeout cycle still counts as success
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    mem_req   = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_req = hz.MemAccessM_i;
        if (hz.MemAccessM_i && !hz.MemReady_i) begin
          state_d   = WAIT;
          cnt_d     = TIMEOUT_WIDTH'(1);
          mem_stall = 1'b1;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        cnt_d   = cnt_q + TIMEOUT_WIDTH'(1);
        if (hz.MemReady_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          cnt_d     = '0;
          mem_err_d = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Hazard priority: a frozen memory stage masks branch redirects and load-use bubbles
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE_i) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.MemReq_o    = rst_ni & mem_req;
  assign hz.StallF_o    = rst_ni & stall_f;
  assign hz.StallD_o    = rst_ni & stall_d;
  assign hz.StallE_o    = rst_ni & stall_e;
  assign hz.StallM_o    = rst_ni & stall_m;
  assign hz.FlushD_o    = rst_ni & flush_d;
  assign hz.FlushE_o    = rst_ni & flush_e;
  assign hz.FlushW_o    = rst_ni & flush_w;
  assign hz.ForwardAE_o = rst_ni ? fwd_a : FWD_REG;
  assign hz.ForwardBE_o = rst_ni ? fwd_b : FWD_REG;
  assign hz.MemErr_o    = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_CNT_W-1:0] lw_cnt_q, lw_cnt_d;

  // flush_d only fires on the branch path; stall_f without stall_m only on the load-use path
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    lw_cnt_d    = lw_cnt_q;
    if (stall_f)            stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
    if (flush_d)            flush_cnt_d = flush_cnt_q + PERF_CNT_W'(1);
    if (stall_f && !stall_m) lw_cnt_d   = lw_cnt_q + PERF_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lw_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lw_cnt_q    <= lw_cnt_d;
    end
  end

  assign hz.StallCnt_o   = stall_cnt_q;
  assign hz.FlushCnt_o   = flush_cnt_q;
  assign hz.LwStallCnt_o = lw_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4).
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.RAW(5)) hz ();

  hazard_ctrl #(
    .REGISTER_ADDRESS_WIDTH (5),
    .MEM_TIMEOUT            (4),
    .TIMEOUT_WIDTH          (3)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hz     (hz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hz.Rs1D_i = '0; hz.Rs2D_i = '0; hz.Rs1E_i = '0; hz.Rs2E_i = '0;
    hz.RdE_i = '0; hz.RdM_i = '0; hz.RdW_i = '0;
    hz.RegWriteM_i = 1'b0; hz.RegWriteW_i = 1'b0; hz.ResultSrcE_i = 2'b00;
    hz.PCSrcE_i = 1'b0; hz.MemAccessM_i = 1'b0; hz.MemReady_i = 1'b0;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    // Under reset every combinational output is forced low
    hz.RegWriteM_i = 1'b1; hz.RdM_i = 5'd5; hz.Rs1E_i = 5'd5;
    hz.ResultSrcE_i = 2'b01; hz.RdE_i = 5'd7; hz.Rs1D_i = 5'd7;
    hz.MemAccessM_i = 1'b1;
    #2;
    chk("rst_fwd_a", 32'(hz.ForwardAE_o), 32'd0);
    chk("rst_stall_f", 32'(hz.StallF_o), 32'd0);
    chk("rst_flush_e", 32'(hz.FlushE_o), 32'd0);
    chk("rst_mem_req", 32'(hz.MemReq_o), 32'd0);
    chk("rst_mem_err", 32'(hz.MemErr_o), 32'd0);

    @(negedge clk); clr(); rst_n = 1'b1; #1;
    chk("idle_stall_f", 32'(hz.StallF_o), 32'd0);
    chk("idle_mem_req", 32'(hz.MemReq_o), 32'd0);

    // Forwarding
    @(negedge clk); clr(); hz.RegWriteM_i = 1'b1; hz.RdM_i = 5'd5; hz.Rs1E_i = 5'd5; #1;
    chk("fwd_a_mem", 32'(hz.ForwardAE_o), 32'd2);
    chk("fwd_b_none", 32'(hz.ForwardBE_o), 32'd0);
    hz.RdM_i = 5'd0; #1;
    chk("fwd_a_rdm0", 32'(hz.ForwardAE_o), 32'd0);
    hz.Rs1E_i = 5'd0; #1;
    chk("fwd_a_x0", 32'(hz.ForwardAE_o), 32'd0);
    @(negedge clk); clr(); hz.RegWriteW_i = 1'b1; hz.RdW_i = 5'd6; hz.Rs1E_i = 5'd6; #1;
    chk("fwd_a_wb", 32'(hz.ForwardAE_o), 32'd1);
    hz.RegWriteW_i = 1'b0; #1;
    chk("fwd_a_wb_nowr", 32'(hz.ForwardAE_o), 32'd0);
    @(negedge clk); clr();
    hz.RegWriteM_i = 1'b1; hz.RdM_i = 5'd5; hz.RegWriteW_i = 1'b1; hz.RdW_i = 5'd5; hz.Rs2E_i = 5'd5; #1;
    chk("fwd_b_mem_prio", 32'(hz.ForwardBE_o), 32'd2);
    hz.RegWriteM_i = 1'b0; #1;
    chk("fwd_b_wb", 32'(hz.ForwardBE_o), 32'd1);

    // Load-use and branch priority
    @(negedge clk); clr(); hz.ResultSrcE_i = 2'b01; hz.RdE_i = 5'd7; hz.Rs2D_i = 5'd7; #1;
    chk("lw_stall_f", 32'(hz.StallF_o), 32'd1);
    chk("lw_stall_d", 32'(hz.StallD_o), 32'd1);
    chk("lw_flush_e", 32'(hz.FlushE_o), 32'd1);
    chk("lw_flush_d", 32'(hz.FlushD_o), 32'd0);
    chk("lw_stall_e", 32'(hz.StallE_o), 32'd0);
    hz.PCSrcE_i = 1'b1; #1;
    chk("br_flush_d", 32'(hz.FlushD_o), 32'd1);
    chk("br_flush_e", 32'(hz.FlushE_o), 32'd1);
    chk("br_stall_f", 32'(hz.StallF_o), 32'd0);
    chk("br_stall_d", 32'(hz.StallD_o), 32'd0);
    @(negedge clk); clr(); #1;
    chk("lw_done_stall_f", 32'(hz.StallF_o), 32'd0);
    chk("lw_done_flush_e", 32'(hz.FlushE_o), 32'd0);
    hz.ResultSrcE_i = 2'b01; hz.RdE_i = 5'd0; hz.Rs1D_i = 5'd0; #1;
    chk("lw_rd0", 32'(hz.StallF_o), 32'd0);
    hz.ResultSrcE_i = 2'b10; hz.RdE_i = 5'd7; hz.Rs1D_i = 5'd7; #1;
    chk("lw_not_load", 32'(hz.StallF_o), 32'd0);
    hz.ResultSrcE_i = 2'b01; #1;
    chk("lw_rs1", 32'(hz.StallD_o), 32'd1);

    // Memory wait: three not-ready cycles then ready
    @(negedge clk); clr(); hz.MemAccessM_i = 1'b1; #1;
    chk("mw1_req", 32'(hz.MemReq_o), 32'd1);
    chk("mw1_stall_m", 32'(hz.StallM_o), 32'd1);
    chk("mw1_stall_f", 32'(hz.StallF_o), 32'd1);
    chk("mw1_stall_e", 32'(hz.StallE_o), 32'd1);
    chk("mw1_flush_w", 32'(hz.FlushW_o), 32'd1);
    chk("mw1_flush_d", 32'(hz.FlushD_o), 32'd0);
    @(negedge clk); hz.PCSrcE_i = 1'b1; hz.ResultSrcE_i = 2'b01; hz.RdE_i = 5'd7; hz.Rs1D_i = 5'd7; #1;
    chk("mw2_stall_m", 32'(hz.StallM_o), 32'd1);
    chk("mw2_flush_d", 32'(hz.FlushD_o), 32'd0);
    chk("mw2_flush_e", 32'(hz.FlushE_o), 32'd0);
    chk("mw2_req", 32'(hz.MemReq_o), 32'd1);
    @(negedge clk); clr(); hz.MemAccessM_i = 1'b1; #1;
    chk("mw3_stall_m", 32'(hz.StallM_o), 32'd1);
    chk("mw3_flush_w", 32'(hz.FlushW_o), 32'd1);
    @(negedge clk); hz.MemReady_i = 1'b1; #1;
    chk("mw4_stall_m", 32'(hz.StallM_o), 32'd0);
    chk("mw4_stall_f", 32'(hz.StallF_o), 32'd0);
    chk("mw4_flush_w", 32'(hz.FlushW_o), 32'd0);
    chk("mw4_req", 32'(hz.MemReq_o), 32'd1);
    @(negedge clk); clr(); #1;
    chk("mw5_req", 32'(hz.MemReq_o), 32'd0);
    chk("mw5_stall_m", 32'(hz.StallM_o), 32'd0);
    chk("mw5_err", 32'(hz.MemErr_o), 32'd0);

    // Ready in IDLE without an access is ignored; a hit access never stalls
    @(negedge clk); clr(); hz.MemReady_i = 1'b1; #1;
    chk("rdy_only_req", 32'(hz.MemReq_o), 32'd0);
    chk("rdy_only_stall", 32'(hz.StallF_o), 32'd0);
    hz.MemAccessM_i = 1'b1; #1;
    chk("hit_req", 32'(hz.MemReq_o), 32'd1);
    chk("hit_stall", 32'(hz.StallM_o), 32'd0);
    @(negedge clk); clr(); #1;
    chk("hit_back_idle", 32'(hz.MemReq_o), 32'd0);

    // Timeout: four stall cycles, error latched on the fifth edge
    @(negedge clk); clr(); hz.MemAccessM_i = 1'b1; #1;
    chk("to1_stall", 32'(hz.StallM_o), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to%0d_stall", i), 32'(hz.StallM_o), 32'd1);
      chk($sformatf("to%0d_err", i), 32'(hz.MemErr_o), 32'd0);
    end
    @(negedge clk); #1;
    chk("to5_stall", 32'(hz.StallM_o), 32'd0);
    chk("to5_req", 32'(hz.MemReq_o), 32'd1);
    chk("to5_err", 32'(hz.MemErr_o), 32'd0);
    @(negedge clk); clr(); #1;
    chk("to_err_set", 32'(hz.MemErr_o), 32'd1);
    chk("to_idle_req", 32'(hz.MemReq_o), 32'd0);
    @(negedge clk); #1;
    chk("to_err_sticky", 32'(hz.MemErr_o), 32'd1);

    // Asynchronous reset in the middle of WAIT
    @(negedge clk); clr(); hz.MemAccessM_i = 1'b1; #1;
    @(negedge clk); #1;
    chk("arst_pre_req", 32'(hz.MemReq_o), 32'd1);
    hz.RegWriteM_i = 1'b1; hz.RdM_i = 5'd5; hz.Rs1E_i = 5'd5;
    rst_n = 1'b0; #1;
    chk("arst_req", 32'(hz.MemReq_o), 32'd0);
    chk("arst_stall_m", 32'(hz.StallM_o), 32'd0);
    chk("arst_flush_w", 32'(hz.FlushW_o), 32'd0);
    chk("arst_fwd_a", 32'(hz.ForwardAE_o), 32'd0);
    chk("arst_err", 32'(hz.MemErr_o), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("arst_stall_cnt", hz.StallCnt_o, 32'd0);
    chk("arst_flush_cnt", hz.FlushCnt_o, 32'd0);
    chk("arst_lw_cnt", hz.LwStallCnt_o, 32'd0);
`endif
    @(negedge clk); clr(); rst_n = 1'b1; #1;
    chk("arst_idle_req", 32'(hz.MemReq_o), 32'd0);

    // Ready and timeout coincide: success, no error
    @(negedge clk); clr(); hz.MemAccessM_i = 1'b1; #1;
    chk("rw1_stall", 32'(hz.StallM_o), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rw%0d_stall", i), 32'(hz.StallM_o), 32'd1);
    end
    @(negedge clk); hz.MemReady_i = 1'b1; #1;
    chk("rw5_stall", 32'(hz.StallM_o), 32'd0);
    @(negedge clk); clr(); #1;
    chk("rw_no_err", 32'(hz.MemErr_o), 32'd0);
    chk("rw_idle_req", 32'(hz.MemReq_o), 32'd0);

    // One load-use cycle and one branch cycle to feed the event counters
    @(negedge clk); clr(); hz.ResultSrcE_i = 2'b01; hz.RdE_i = 5'd3; hz.Rs2D_i = 5'd3; #1;
    chk("perf_lw_stall", 32'(hz.StallF_o), 32'd1);
    @(negedge clk); clr(); hz.PCSrcE_i = 1'b1; #1;
    chk("perf_br_flush", 32'(hz.FlushD_o), 32'd1);
    @(negedge clk); clr(); #1;
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt", hz.StallCnt_o, 32'd5);
    chk("perf_flush_cnt", hz.FlushCnt_o, 32'd1);
    chk("perf_lw_cnt", hz.LwStallCnt_o, 32'd1);
`endif
    chk("end_stall_f", 32'(hz.StallF_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It generates stall and flush controls for the F/D/E/M/W pipeline registers and operand forwarding selects for the execute stage. It also runs a wait-state FSM for a multi-cycle data memory, with a timeout. It sits beside the datapath and drives the clear/enable inputs of every pip_reg_* stage.

Parameters:
REGISTER_ADDRESS_WIDTH, 5, register index width
MEM_TIMEOUT, 16, maximum WAIT cycles before a memory error; must be ≥2
TIMEOUT_WIDTH, 5, width of the wait counter; must be ≥ clog2(MEM_TIMEOUT+1)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
Rs1D_i, Rs2D_i  in  RAW  source registers in Decode
Rs1E_i, Rs2E_i  in  RAW  source registers in Execute
RdE_i, RdM_i, RdW_i  in  RAW  destination registers in E/M/W
RegWriteM_i, RegWriteW_i  in  1  write enables in M/W
ResultSrcE_i  in  2  result source in E; 2'b01 = load
PCSrcE_i  in  1  branch taken or jump, resolved in E
MemAccessM_i  in  1  load/store in Memory stage
MemReady_i  in  1  data memory done
MemReq_o  out  1  data memory request
StallF_o, StallD_o, StallE_o, StallM_o  out  1  hold stage register
FlushD_o, FlushE_o, FlushW_o  out  1  bubble stage register
ForwardAE_o, ForwardBE_o  out  2  00 regfile, 01 W result, 10 M ALU result
MemErr_o  out  1  sticky memory timeout flag
(RAW = REGISTER_ADDRESS_WIDTH)

Behaviour:
- Clocking: single clock clk_i. Reset rst_ni is asynchronous and active-low.
- Reset: FSM goes to IDLE, counter = 0, MemErr_o = 0. While rst_ni = 0, all stall, flush, forward and MemReq_o outputs are forced to 0.
- Forwarding (combinational), ForwardAE_o:
  - 10 if RegWriteM_i and RdM_i != 0 and RdM_i == Rs1E_i.
  - Otherwise 01 if RegWriteW_i and RdW_i != 0 and RdW_i == Rs1E_i.
  - Otherwise 00.
  - M takes priority over W. ForwardBE_o is identical using Rs2E_i.
- Load-use: lwStall = (ResultSrcE_i == 01) and RdE_i != 0 and (RdE_i == Rs1D_i or RdE_i == Rs2D_i).
- FSM states:
  - IDLE: MemReq_o = MemAccessM_i. If MemAccessM_i and not MemReady_i, go to WAIT and set counter = 1. Otherwise stay in IDLE.
  - WAIT: MemReq_o = 1 and the counter increments each cycle.
    - If MemReady_i, go to IDLE.
    - Else if counter == MEM_TIMEOUT, set MemErr_o = 1 (sticky until reset) and go to IDLE.
    - MemReady_i and timeout in the same cycle: ready wins and MemErr_o is not set.
- memStall = (IDLE and MemAccessM_i and not MemReady_i) or (WAIT and not MemReady_i and counter != MEM_TIMEOUT).
- Priority, highest first:
  1. memStall: StallF/D/E/M = 1, FlushW = 1, FlushD = FlushE = 0. PCSrcE_i and lwStall are ignored because E is frozen.
  2. PCSrcE_i: FlushD = FlushE = 1, all stalls = 0. This overrides lwStall.
  3. lwStall: StallF = StallD = 1, FlushE = 1.
  4. None: all stall and flush outputs = 0.
- Latency: stall/flush/forward outputs are combinational, valid in the same cycle as their inputs. Only FSM state, counter and MemErr_o are registered.
- MemReady_i asserted in IDLE without MemAccessM_i is ignored.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Adds 32-bit outputs StallCnt_o, FlushCnt_o and LwStallCnt_o.
  - StallCnt_o increments each cycle StallF_o = 1.
  - FlushCnt_o increments each cycle PCSrcE_i causes a flush.
  - LwStallCnt_o increments each cycle the lwStall branch is taken.
  - All counters wrap at 2^32 and reset to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e: FWD_REG = 00, FWD_WB = 01, FWD_MEM = 10.
  - mem_state_e: IDLE, WAIT.
  - localparam RESULT_SRC_LOAD = 2'b01.
- Sub-module fwd_sel: combinational forward select for one operand, instantiated twice (A, B).

Test Plan:
- add x5 in M, Rs1E = 5, RegWriteM = 1 → ForwardAE = 10. Same with RdM = 0 → ForwardAE = 00.
- RdM = 5 and RdW = 5 both writing, Rs2E = 5 → ForwardBE = 10 (M priority).
- Load in E with RdE = 7, Rs2D = 7 → StallF = StallD = FlushE = 1 for one cycle. Add PCSrcE = 1 in the same cycle → FlushD = FlushE = 1, StallF = 0.
- MemAccessM = 1, MemReady low for 3 cycles then high → MemReq = 1 and StallM = 1 for exactly 3 cycles. FlushW = 1 during those cycles. Return to IDLE on the 4th cycle with no stall.
- MEM_TIMEOUT = 4, MemReady never rises → stall lasts 4 cycles. MemErr_o = 1 from the next edge and holds until rst_ni = 0.
- Assert rst_ni = 0 mid-WAIT → asynchronous return to IDLE, all outputs 0. With HAZARD_PERF_EN, the counters also read 0.
